// File: rtl/rgb_batch_sequencer_if.sv
// Command and result handshake bundle between a batch master and rgb_batch_sequencer.
// master drives commands and consumes results; slave is the sequencer side.
interface rgb_batch_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 24,
    parameter int OP_W   = 3
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_count;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_rgb;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_rgb;
    logic [ADDR_W-1:0] res_addr;
    logic              res_last;

    modport master (
        output cmd_valid, cmd_addr, cmd_count, cmd_op, cmd_rgb, res_ready,
        input  cmd_ready, res_valid, res_rgb, res_addr, res_last
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_count, cmd_op, cmd_rgb, res_ready,
        output cmd_ready, res_valid, res_rgb, res_addr, res_last
    );
endinterface

// File: rtl/rgb_batch_sequencer.sv
// Batch sequencer driving the 16-entry RGB mask unit one element at a time, streaming results out.
// Optional feature macro: RGB_SEQ_CHECKSUM_EN adds checksum_o (XOR of results issued in the batch).
module rgb_batch_sequencer #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 24,
    parameter int OP_W   = 3,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    rgb_batch_sequencer_if.slave bus,
    output logic                busy_o,
    output logic                mem_mode_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_rgbin_o,
    output logic [OP_W-1:0]     mem_op_o,
`ifdef RGB_SEQ_CHECKSUM_EN
    output logic [DATA_W-1:0]   checksum_o,
`endif
    input  logic [DATA_W-1:0]   mem_rgbout_i
);

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_READ, S_WAIT, S_OUT} state_t;

    localparam int CNT_W     = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam int WAIT_LAST = (SETTLE > 1) ? (SETTLE - 2) : 0;
    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q;
    logic [ADDR_W:0]   remaining_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              cmd_ready_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_rgb_q;
    logic [ADDR_W-1:0] res_addr_q;
    logic              res_last_q;
    logic              busy_q;
    logic              mem_mode_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_rgbin_q;
    logic [OP_W-1:0]   mem_op_q;
    logic              accept_s;
    logic              capture_s;

    // Command accept and result capture strobes for the current state.
    always_comb begin
        accept_s  = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            S_IDLE:  accept_s  = bus.cmd_valid & cmd_ready_q;
            S_READ:  capture_s = (SETTLE == 1) ? 1'b1 : 1'b0;
            S_WAIT:  capture_s = (wait_cnt_q == CNT_W'(WAIT_LAST)) ? 1'b1 : 1'b0;
            default: begin
                accept_s  = 1'b0;
                capture_s = 1'b0;
            end
        endcase
    end

    // Sequencer FSM; MEM_ADDR doubles as the current element address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_rgb_q   <= '0;
            res_addr_q  <= '0;
            res_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            mem_mode_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_rgbin_q <= '0;
            mem_op_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        mem_mode_q  <= 1'b1;
                        mem_addr_q  <= bus.cmd_addr;
                        mem_op_q    <= bus.cmd_op;
                        mem_rgbin_q <= bus.cmd_rgb;
                        remaining_q <= (bus.cmd_count == '0) ? FULL_COUNT : {1'b0, bus.cmd_count};
                        state_q     <= S_APPLY;
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                S_APPLY: begin
                    mem_mode_q <= 1'b0;
                    state_q    <= S_READ;
                end
                S_READ: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (res_last_q) begin
                            busy_q      <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            remaining_q <= remaining_q - (ADDR_W+1)'(1);
                            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                            mem_mode_q  <= 1'b1;
                            state_q     <= S_APPLY;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    mem_mode_q  <= 1'b0;
                    res_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b0;
                end
            endcase
            // Capture overrides the READ/WAIT transitions above once settling is done.
            if (capture_s) begin
                res_rgb_q   <= mem_rgbout_i;
                res_addr_q  <= mem_addr_q;
                res_last_q  <= (remaining_q == (ADDR_W+1)'(1));
                res_valid_q <= 1'b1;
                state_q     <= S_OUT;
            end
        end
    end

`ifdef RGB_SEQ_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;

    // Running XOR of the results captured in the current batch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (accept_s) begin
            checksum_q <= '0;
        end else if (capture_s) begin
            checksum_q <= checksum_q ^ mem_rgbout_i;
        end
    end

    assign checksum_o = checksum_q;
`endif

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_rgb   = res_rgb_q;
    assign bus.res_addr  = res_addr_q;
    assign bus.res_last  = res_last_q;
    assign busy_o        = busy_q;
    assign mem_mode_o    = mem_mode_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_rgbin_o   = mem_rgbin_q;
    assign mem_op_o      = mem_op_q;

endmodule
